// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the IF / data SRAM port arbiter.
package sram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,
    RESP_INST = 2'b01,
    RESP_DATA = 2'b10
  } resp_sel_e;

  // Bit position of the arbiter's entry in the CTRL stall-request vector.
  localparam int unsigned ARB_STALL = 1;

  function automatic int unsigned starve_w(input int unsigned max_starve);
    return (max_starve == 0) ? 1 : $clog2(max_starve + 1);
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester and SRAM-side signals of the arbiter, bundled with role modports.
interface sram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic [3:0]        d_wen;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic [3:0]        mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stallreq_for_arb;

    modport slave (
        input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_wen, mem_addr, mem_wdata, stallreq_for_arb
    );

    modport master (
        output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_wen, mem_addr, mem_wdata, stallreq_for_arb
    );
endinterface

// File: rtl/sram_port_arbiter_arb_rsp_hold.sv
// Per-requester response stage: live SRAM data on the response cycle, held copy otherwise.
module arb_rsp_hold #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel_match,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] hold_q, hold_d;

    always_comb begin
        hold_d = sel_match ? mem_rdata : hold_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_q <= '0;
        else     hold_q <= hold_d;
    end

    assign rvalid = sel_match;
    assign rdata  = sel_match ? mem_rdata : hold_q;
endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: data-priority grant with an IF starvation guard.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic               clk,
    input  logic               rst,
    sram_port_arbiter_if.slave bus
);
    localparam int unsigned   SW         = starve_w(MAX_STARVE);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    resp_sel_e     resp_sel_q, resp_sel_d;
    logic          i_gnt, d_gnt;

    // Grants are forced low during reset so every output is 0 without a clock edge.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (bus.i_req && bus.d_req) begin
                if (starve_cnt_q >= STARVE_MAX) i_gnt = 1'b1;
                else                            d_gnt = 1'b1;
            end else begin
                i_gnt = bus.i_req;
                d_gnt = bus.d_req;
            end
        end
    end

    assign bus.i_gnt     = i_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.mem_en    = i_gnt | d_gnt;
    assign bus.mem_wen   = d_gnt ? bus.d_wen : '0;
    assign bus.mem_addr  = i_gnt ? bus.i_addr : (d_gnt ? bus.d_addr : '0);
    assign bus.mem_wdata = d_gnt ? bus.d_wdata : '0;
    assign bus.stallreq_for_arb = ~rst & ((bus.i_req & ~i_gnt) | (bus.d_req & ~d_gnt));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.i_req || i_gnt)
            starve_cnt_d = '0;
        else if (d_gnt && (starve_cnt_q != STARVE_MAX))
            starve_cnt_d = starve_cnt_q + 1'b1;
    end

    always_comb begin
        resp_sel_d = RESP_NONE;
        if (i_gnt)                          resp_sel_d = RESP_INST;
        else if (d_gnt && bus.d_wen == '0)  resp_sel_d = RESP_DATA;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
            resp_sel_q   <= RESP_NONE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            resp_sel_q   <= resp_sel_d;
        end
    end

    arb_rsp_hold #(.DATA_W(DATA_W)) u_inst_rsp (
        .clk       (clk),
        .rst       (rst),
        .sel_match (resp_sel_q == RESP_INST),
        .mem_rdata (bus.mem_rdata),
        .rvalid    (bus.i_rvalid),
        .rdata     (bus.i_rdata)
    );

    arb_rsp_hold #(.DATA_W(DATA_W)) u_data_rsp (
        .clk       (clk),
        .rst       (rst),
        .sel_match (resp_sel_q == RESP_DATA),
        .mem_rdata (bus.mem_rdata),
        .rvalid    (bus.d_rvalid),
        .rdata     (bus.d_rdata)
    );
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter.
module tb_sram_port_arbiter;
    logic clk;
    logic rst;
    int unsigned checks;
    int unsigned failures;

    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STARVE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.d_req     = 1'b0;
        bus.d_wen     = '0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        #2;
        checks++;
        if (bus.i_gnt !== 1'b0 || bus.d_gnt !== 1'b0) begin
            failures++;
            $display("FAIL reset_gnt got i=%b d=%b exp 0 0", bus.i_gnt, bus.d_gnt);
        end
        checks++;
        if (bus.mem_en !== 1'b0 || bus.mem_addr !== 32'h0 || bus.stallreq_for_arb !== 1'b0) begin
            failures++;
            $display("FAIL reset_mem got en=%b addr=%h stall=%b exp 0", bus.mem_en, bus.mem_addr, bus.stallreq_for_arb);
        end
        checks++;
        if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rsp got iv=%b dv=%b ird=%h drd=%h exp 0", bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata);
        end
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
    endtask

    task automatic test_idle();
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (bus.mem_en !== 1'b0 || bus.mem_wen !== 4'h0 || bus.i_gnt !== 1'b0 || bus.d_gnt !== 1'b0 ||
            bus.stallreq_for_arb !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL idle got en=%b wen=%h ig=%b dg=%b stall=%b addr=%h wd=%h exp all 0",
                     bus.mem_en, bus.mem_wen, bus.i_gnt, bus.d_gnt, bus.stallreq_for_arb, bus.mem_addr, bus.mem_wdata);
        end
    endtask

    task automatic test_if_read();
        @(negedge clk);
        bus.i_req  = 1'b1;
        bus.i_addr = 32'hBFC0_0000;
        #1;
        checks++;
        if (bus.i_gnt !== 1'b1 || bus.d_gnt !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_wen !== 4'h0 ||
            bus.mem_addr !== 32'hBFC0_0000 || bus.stallreq_for_arb !== 1'b0) begin
            failures++;
            $display("FAIL if_grant got ig=%b dg=%b en=%b wen=%h addr=%h stall=%b exp 1 0 1 0 bfc00000 0",
                     bus.i_gnt, bus.d_gnt, bus.mem_en, bus.mem_wen, bus.mem_addr, bus.stallreq_for_arb);
        end
        @(negedge clk);
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.mem_rdata = 32'h3C01_0000;
        #1;
        checks++;
        if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'h3C01_0000 || bus.d_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL if_resp got iv=%b ird=%h dv=%b exp 1 3c010000 0", bus.i_rvalid, bus.i_rdata, bus.d_rvalid);
        end
        @(negedge clk);
        bus.mem_rdata = 32'h0;
        #1;
        checks++;
        if (bus.i_rvalid !== 1'b0 || bus.i_rdata !== 32'h3C01_0000) begin
            failures++;
            $display("FAIL if_hold got iv=%b ird=%h exp 0 3c010000", bus.i_rvalid, bus.i_rdata);
        end
    endtask

    task automatic test_conflict();
        @(negedge clk);
        bus.i_req  = 1'b1;
        bus.i_addr = 32'hBFC0_0004;
        bus.d_req  = 1'b1;
        bus.d_wen  = 4'h0;
        bus.d_addr = 32'h8000_0010;
        #1;
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.i_gnt !== 1'b0 || bus.stallreq_for_arb !== 1'b1 || bus.mem_addr !== 32'h8000_0010) begin
            failures++;
            $display("FAIL conflict_grant got dg=%b ig=%b stall=%b addr=%h exp 1 0 1 80000010",
                     bus.d_gnt, bus.i_gnt, bus.stallreq_for_arb, bus.mem_addr);
        end
        @(negedge clk);
        bus.d_req     = 1'b0;
        bus.d_addr    = '0;
        bus.mem_rdata = 32'h1234_5678;
        #1;
        checks++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL conflict_dresp got dv=%b drd=%h exp 1 12345678", bus.d_rvalid, bus.d_rdata);
        end
        checks++;
        if (bus.i_gnt !== 1'b1 || bus.stallreq_for_arb !== 1'b0 || bus.mem_addr !== 32'hBFC0_0004) begin
            failures++;
            $display("FAIL conflict_igrant got ig=%b stall=%b addr=%h exp 1 0 bfc00004", bus.i_gnt, bus.stallreq_for_arb, bus.mem_addr);
        end
        @(negedge clk);
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.mem_rdata = 32'hAABB_CCDD;
        #1;
        checks++;
        if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'hAABB_CCDD || bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL conflict_iresp got iv=%b ird=%h dv=%b drd=%h exp 1 aabbccdd 0 12345678",
                     bus.i_rvalid, bus.i_rdata, bus.d_rvalid, bus.d_rdata);
        end
    endtask

    task automatic test_write();
        @(negedge clk);
        bus.mem_rdata = 32'h0;
        bus.d_req     = 1'b1;
        bus.d_wen     = 4'b0001;
        bus.d_addr    = 32'h8000_0020;
        bus.d_wdata   = 32'h0000_00AB;
        #1;
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.mem_wen !== 4'b0001 || bus.mem_wdata !== 32'h0000_00AB ||
            bus.mem_addr !== 32'h8000_0020 || bus.mem_en !== 1'b1) begin
            failures++;
            $display("FAIL write_grant got dg=%b wen=%h wd=%h addr=%h en=%b exp 1 1 000000ab 80000020 1",
                     bus.d_gnt, bus.mem_wen, bus.mem_wdata, bus.mem_addr, bus.mem_en);
        end
        @(negedge clk);
        drive_idle();
        bus.mem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'h1234_5678 || bus.i_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL write_norsp got dv=%b drd=%h iv=%b exp 0 12345678 0", bus.d_rvalid, bus.d_rdata, bus.i_rvalid);
        end
    endtask

    task automatic test_starvation();
        logic [5:0] exp_i;
        exp_i = 6'b01_0000;
        @(negedge clk);
        drive_idle();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.i_req  = 1'b1;
            bus.i_addr = 32'hBFC0_0100;
            bus.d_req  = 1'b1;
            bus.d_addr = 32'h8000_0100;
            #1;
            checks++;
            if (bus.i_gnt !== exp_i[i] || bus.d_gnt !== ~exp_i[i] || bus.stallreq_for_arb !== 1'b1) begin
                failures++;
                $display("FAIL starve_cycle%0d got ig=%b dg=%b stall=%b exp ig=%b dg=%b stall=1",
                         i, bus.i_gnt, bus.d_gnt, bus.stallreq_for_arb, exp_i[i], ~exp_i[i]);
            end
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive_idle();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0100;
        #1;
        checks++;
        if (bus.i_gnt !== 1'b1 || bus.mem_addr !== 32'h0000_0100) begin
            failures++;
            $display("FAIL b2b_igrant got ig=%b addr=%h exp 1 00000100", bus.i_gnt, bus.mem_addr);
        end
        @(negedge clk);
        bus.i_req     = 1'b0;
        bus.d_req     = 1'b1;
        bus.d_addr    = 32'h0000_0200;
        bus.mem_rdata = 32'h1111_1111;
        #1;
        checks++;
        if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'h1111_1111 || bus.d_gnt !== 1'b1 || bus.mem_addr !== 32'h0000_0200) begin
            failures++;
            $display("FAIL b2b_iresp_dgrant got iv=%b ird=%h dg=%b addr=%h exp 1 11111111 1 00000200",
                     bus.i_rvalid, bus.i_rdata, bus.d_gnt, bus.mem_addr);
        end
        @(negedge clk);
        bus.d_req     = 1'b0;
        bus.mem_rdata = 32'h2222_2222;
        #1;
        checks++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h2222_2222 || bus.i_rvalid !== 1'b0 || bus.i_rdata !== 32'h1111_1111) begin
            failures++;
            $display("FAIL b2b_dresp got dv=%b drd=%h iv=%b ird=%h exp 1 22222222 0 11111111",
                     bus.d_rvalid, bus.d_rdata, bus.i_rvalid, bus.i_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        drive_idle();
        bus.d_req     = 1'b1;
        bus.d_addr    = 32'h8000_0040;
        bus.mem_rdata = 32'h7777_7777;
        #1;
        checks++;
        if (bus.d_gnt !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_grant got dg=%b exp 1", bus.d_gnt);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.d_gnt !== 1'b0 || bus.mem_en !== 1'b0 || bus.mem_addr !== 32'h0 || bus.stallreq_for_arb !== 1'b0 ||
            bus.d_rdata !== 32'h0 || bus.i_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_async got dg=%b en=%b addr=%h stall=%b drd=%h ird=%h exp all 0",
                     bus.d_gnt, bus.mem_en, bus.mem_addr, bus.stallreq_for_arb, bus.d_rdata, bus.i_rdata);
        end
        @(negedge clk);
        bus.d_req = 1'b0;
        rst       = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_nopulse got dv=%b drd=%h exp 0 00000000", bus.d_rvalid, bus.d_rdata);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_idle();
        test_if_read();
        test_conflict();
        test_write();
        test_starvation();
        test_idle();
        test_back_to_back();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end
endmodule
